// File: rtl/rtl_trace_pkg.sv
// Shared definitions for the RTL trace buffer: FSM state encoding and a
// compile-time log2 helper used to size pointers.
package rtl_trace_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StWait = 3'd2,
    StPost = 3'd3,
    StRun  = 3'd4,
    StDone = 3'd5
  } trace_state_e;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rtl_trace_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset so it maps onto block RAM.
module rtl_trace_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned Words = 1 << AW;

  logic [WIDTH-1:0] mem [Words];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rtl_trace_buffer.sv
// Probe-group trace buffer: pre/post-trigger single-shot capture or rolling
// capture into a ring buffer, read back relative to the oldest sample.
module rtl_trace_buffer
  import rtl_trace_pkg::*;
#(
  parameter int unsigned GROUPS  = 4,
  parameter int unsigned GROUP_W = 32,
  parameter int unsigned DEPTH   = 256,
  localparam int unsigned AW     = log2_ceil(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [GROUPS*GROUP_W-1:0] probe_in,
  input  logic [7:0]                group_sel,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      single_shot,
  input  logic [AW-1:0]             pretrig_len,
  input  logic [GROUP_W-1:0]        trig_mask,
  input  logic [GROUP_W-1:0]        trig_value,
  input  logic [GROUP_W-1:0]        trig_edge,
  input  logic [AW-1:0]             rd_index,
  output logic [GROUP_W-1:0]        rd_data,
  output logic [GROUP_W-1:0]        live,
  output logic [2:0]                state,
  output logic                      triggered,
  output logic                      done,
  output logic [AW-1:0]             trig_index
);

  localparam logic [AW:0]   CntOne   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CntDepth = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PtrOne   = {{(AW-1){1'b0}}, 1'b1};

  trace_state_e state_q, state_d;

  logic [7:0]         sel_q;
  logic [GROUP_W-1:0] mask_q, value_q, edge_q;
  logic [AW-1:0]      pre_q;
  logic [GROUP_W-1:0] s0_q, s0_prev_q, sel_data;
  logic [AW-1:0]      wptr_q, trig_ptr_q, oldest_q, trig_index_q;
  logic [AW:0]        fill_q, post_q, post_total;
  logic               triggered_q, rd_valid_q;
  logic [GROUP_W-1:0] ram_rd;

  logic          capturing, arm_ok, hit, trig_set, finish, wrapped;
  logic [7:0]    sel_eff;
  logic [AW-1:0] oldest_d, ref_ptr;

  assign capturing  = state_q inside {StPre, StWait, StPost, StRun};
  assign arm_ok     = arm && !abort && (state_q == StIdle || state_q == StDone);
  // During a capture the group seen at arm time stays selected.
  assign sel_eff    = capturing ? sel_q : group_sel;
  assign post_total = CntDepth - {1'b0, pre_q};
  assign hit = (((s0_q ^ value_q) & mask_q) == '0) &&
               ((edge_q == '0) || (((s0_q ^ s0_prev_q) & edge_q) != '0));

  always_comb begin
    sel_data = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (sel_eff == 8'(g)) sel_data = probe_in[g*GROUP_W +: GROUP_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    trig_set = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (abort) state_d = StIdle;
        else if (arm) begin
          if (!single_shot)             state_d = StRun;
          else if (pretrig_len == '0)   state_d = StWait;
          else                          state_d = StPre;
        end
      end
      StPre: begin
        if (abort) state_d = StIdle;
        else if ((fill_q + CntOne) == {1'b0, pre_q}) state_d = StWait;
      end
      StWait: begin
        if (abort) state_d = StIdle;
        else if (hit) begin
          trig_set = 1'b1;
          if (post_total == CntOne) begin
            state_d = StDone;
            finish  = 1'b1;
          end else begin
            state_d = StPost;
          end
        end
      end
      StPost: begin
        if (abort) state_d = StIdle;
        else if ((post_q + CntOne) == post_total) begin
          state_d = StDone;
          finish  = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDone;
          finish  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Oldest sample is the slot after the final write once the ring has filled.
  assign wrapped  = fill_q >= (CntDepth - CntOne);
  assign oldest_d = wrapped ? (wptr_q + PtrOne) : '0;
  assign ref_ptr  = (state_q == StPost) ? trig_ptr_q : wptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      edge_q       <= '0;
      pre_q        <= '0;
      s0_q         <= '0;
      s0_prev_q    <= '0;
      wptr_q       <= '0;
      trig_ptr_q   <= '0;
      oldest_q     <= '0;
      trig_index_q <= '0;
      fill_q       <= '0;
      post_q       <= '0;
      triggered_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s0_q       <= sel_data;
      s0_prev_q  <= s0_q;
      rd_valid_q <= 1'b1;
      if (arm_ok) begin
        sel_q       <= group_sel;
        mask_q      <= trig_mask;
        value_q     <= trig_value;
        edge_q      <= trig_edge;
        pre_q       <= pretrig_len;
        wptr_q      <= '0;
        fill_q      <= '0;
        post_q      <= '0;
        triggered_q <= 1'b0;
      end
      if (capturing) begin
        wptr_q <= wptr_q + PtrOne;
        if (fill_q != CntDepth) fill_q <= fill_q + CntOne;
      end
      if (trig_set) begin
        trig_ptr_q  <= wptr_q;
        triggered_q <= 1'b1;
        post_q      <= CntOne;
      end else if (state_q == StPost) begin
        post_q <= post_q + CntOne;
      end
      if (finish) begin
        oldest_q     <= oldest_d;
        trig_index_q <= ref_ptr - oldest_d;
      end
    end
  end

  rtl_trace_ram #(
    .WIDTH (GROUP_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (capturing),
    .wr_addr (wptr_q),
    .wr_data (s0_q),
    .rd_addr (oldest_q + rd_index),
    .rd_data (ram_rd)
  );

  // The RAM read register has no reset; mask it until the first clock.
  assign rd_data    = rd_valid_q ? ram_rd : '0;
  assign live       = s0_q;
  assign state      = state_q;
  assign done       = (state_q == StDone);
  assign triggered  = triggered_q;
  assign trig_index = trig_index_q;

endmodule

// File: tb/tb_rtl_trace_buffer.sv
// Directed bench for rtl_trace_buffer with DEPTH=16, four 8-bit probe groups.
module tb_rtl_trace_buffer;

  localparam int unsigned GROUPS  = 4;
  localparam int unsigned GROUP_W = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;

  logic                      clk;
  logic                      rst_n;
  logic [GROUPS*GROUP_W-1:0] probe_in;
  logic [7:0]                group_sel;
  logic                      arm;
  logic                      abort;
  logic                      single_shot;
  logic [AW-1:0]             pretrig_len;
  logic [GROUP_W-1:0]        trig_mask;
  logic [GROUP_W-1:0]        trig_value;
  logic [GROUP_W-1:0]        trig_edge;
  logic [AW-1:0]             rd_index;
  logic [GROUP_W-1:0]        rd_data;
  logic [GROUP_W-1:0]        live;
  logic [2:0]                state;
  logic                      triggered;
  logic                      done;
  logic [AW-1:0]             trig_index;

  int checks;
  int failures;

  rtl_trace_buffer #(
    .GROUPS  (GROUPS),
    .GROUP_W (GROUP_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .probe_in    (probe_in),
    .group_sel   (group_sel),
    .arm         (arm),
    .abort       (abort),
    .single_shot (single_shot),
    .pretrig_len (pretrig_len),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .trig_edge   (trig_edge),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .live        (live),
    .state       (state),
    .triggered   (triggered),
    .done        (done),
    .trig_index  (trig_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input int g, input logic [7:0] v);
    probe_in[g*GROUP_W +: GROUP_W] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; probe_in = '0; group_sel = '0; arm = 1'b0; abort = 1'b0;
    single_shot = 1'b1; pretrig_len = '0; trig_mask = '0; trig_value = '0;
    trig_edge = '0; rd_index = '0;
    #2;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b want=0", triggered); end
    checks++; if (live !== 8'h00) begin failures++; $display("FAIL reset_live got=%h want=00", live); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd got=%h want=00", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pretrig();
    logic [7:0] cnt;
    logic [7:0] exp;
    group_sel = 8'd0; single_shot = 1'b1; pretrig_len = 4'd4;
    trig_mask = 8'hFF; trig_value = 8'h2A; trig_edge = 8'h00;
    cnt = 8'h00; set_group(0, cnt);
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      cnt = cnt + 8'd1; set_group(0, cnt); tick();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL pretrig_done got=%b want=1", done); end
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL pretrig_state got=%0d want=5", state); end
    checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL pretrig_trig got=%b want=1", triggered); end
    checks++; if (trig_index !== 4'd4) begin failures++; $display("FAIL pretrig_tidx got=%0d want=4", trig_index); end
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i); tick();
      exp = 8'h26 + 8'(i);
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL pretrig_rd[%0d] got=%h want=%h", i, rd_data, exp); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL pretrig_hold got=%b want=1", done); end
  endtask

  task automatic test_edge();
    single_shot = 1'b1; pretrig_len = 4'd0; trig_mask = 8'h00; trig_value = 8'h00;
    trig_edge = 8'h01; group_sel = 8'd0;
    set_group(0, 8'h11);
    repeat (3) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL edge_wait got=%0d want=2", state); end
    repeat (5) tick();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL edge_level_state got=%0d want=2", state); end
    checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL edge_level_trig got=%b want=0", triggered); end
    for (int k = 0; k < 40 && done !== 1'b1; k++) begin
      set_group(0, 8'h20 + 8'(k)); tick();
    end
    checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL edge_trig got=%b want=1", triggered); end
    checks++; if (trig_index !== 4'd0) begin failures++; $display("FAIL edge_tidx got=%0d want=0", trig_index); end
    rd_index = 4'd0; tick();
    checks++; if (rd_data !== 8'h20) begin failures++; $display("FAIL edge_rd0 got=%h want=20", rd_data); end
    rd_index = 4'd15; tick();
    checks++; if (rd_data !== 8'h2F) begin failures++; $display("FAIL edge_rd15 got=%h want=2f", rd_data); end
  endtask

  task automatic test_rolling();
    single_shot = 1'b0; group_sel = 8'd0;
    set_group(0, 8'h40);
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL roll_run got=%0d want=4", state); end
    for (int k = 1; k <= 20; k++) begin
      set_group(0, 8'h40 + 8'(k));
      abort = (k == 20);
      tick();
    end
    abort = 1'b0;
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL roll_state got=%0d want=5", state); end
    checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL roll_trig got=%b want=0", triggered); end
    checks++; if (trig_index !== 4'd15) begin failures++; $display("FAIL roll_tidx got=%0d want=15", trig_index); end
    rd_index = 4'd0; tick();
    checks++; if (rd_data !== 8'h44) begin failures++; $display("FAIL roll_rd0 got=%h want=44", rd_data); end
    rd_index = 4'd15; tick();
    checks++; if (rd_data !== 8'h53) begin failures++; $display("FAIL roll_rd15 got=%h want=53", rd_data); end
  endtask

  task automatic test_abort_post();
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL abort_arm_state got=%0d want=0", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_arm_done got=%b want=0", done); end
    single_shot = 1'b1; pretrig_len = 4'd2; trig_mask = 8'h00; trig_edge = 8'h00;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 10 && state !== 3'd3; i++) tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL abort_reach_post got=%0d want=3", state); end
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL post_arm_ignored got=%0d want=3", state); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL post_abort_state got=%0d want=0", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL post_abort_done got=%b want=0", done); end
  endtask

  task automatic test_group_sel();
    probe_in = 32'h44332211;
    group_sel = 8'd2; tick();
    checks++; if (live !== 8'h33) begin failures++; $display("FAIL group2_live got=%h want=33", live); end
    group_sel = 8'd7; tick();
    checks++; if (live !== 8'h00) begin failures++; $display("FAIL group7_live got=%h want=00", live); end
    single_shot = 1'b1; pretrig_len = 4'd0; trig_mask = 8'hFF; trig_value = 8'h00;
    trig_edge = 8'h00;
    arm = 1'b1; tick(); arm = 1'b0;
    group_sel = 8'd0; tick();
    checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL group7_trig got=%b want=1", triggered); end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL group7_state got=%0d want=3", state); end
    checks++; if (live !== 8'h00) begin failures++; $display("FAIL group_latched got=%h want=00", live); end
  endtask

  task automatic test_async_reset();
    abort = 1'b1; tick(); abort = 1'b0;
    group_sel = 8'd1; trig_mask = 8'h00;
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL areset_pre_state got=%0d want=3", state); end
    checks++; if (live !== 8'h22) begin failures++; $display("FAIL areset_pre_live got=%h want=22", live); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL areset_state got=%0d want=0", state); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b want=0", done); end
    checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL areset_trig got=%b want=0", triggered); end
    checks++; if (trig_index !== 4'd0) begin failures++; $display("FAIL areset_tidx got=%0d want=0", trig_index); end
    checks++; if (live !== 8'h00) begin failures++; $display("FAIL areset_live got=%h want=00", live); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL areset_rd got=%h want=00", rd_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_pretrig();
    test_edge();
    test_rolling();
    test_abort_post();
    test_group_sel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
